st_sum_decimator: RTL and testbench

Avalon-ST sink/source block that sits directly downstream of the N-stage pipeline. It consumes one signed sample per accepted beat and accumulates DECIM consecutive samples. It emits one widened sum per DECIM inputs. Backpressure propagates upstream only when a completed sum has nowhere to go, so the upstream pipeline keeps its 1 sample/cycle throughput while the output is drained.

---
 rtl/st_sum_decimator.sv | 103 ++++++++++
 tb/tb_st_sum_decimator.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/st_sum_decimator.sv
`timescale 1ns/1ps
// st_sum_decimator
//   Avalon-ST decimating accumulator. Sums DECIM consecutive signed samples
//   into an ACC_WIDTH accumulator and emits one registered sum per DECIM
//   accepted inputs. Input stalls only when a completed sum cannot be moved
//   into the output register.
//
// Ports:
//   clk        - sole clock, rising edge
//   reset_n    - asynchronous active-low reset
//   clr        - synchronous discard of the partial sum (blocks input that cycle)
//   asi_valid  - upstream sample valid
//   asi_data   - signed sample, DATA_WIDTH bits
//   asi_ready  - combinational: sample accepted this cycle when asi_valid
//   aso_valid  - registered: aso_data holds a completed sum
//   aso_data   - registered signed sum, ACC_WIDTH bits
//   aso_ready  - downstream accepts the sum this cycle
module st_sum_decimator #(
  parameter int DATA_WIDTH = 32,
  parameter int DECIM      = 4,
  parameter int ACC_WIDTH  = 40
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clr,
  input  logic                  asi_valid,
  input  logic [DATA_WIDTH-1:0] asi_data,
  output logic                  asi_ready,
  output logic                  aso_valid,
  output logic [ACC_WIDTH-1:0]  aso_data,
  input  logic                  aso_ready
);

  // One-bit counter when DECIM==1 keeps the vector legal; it stays at 0.
  localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);

  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 aso_valid_q, aso_valid_d;
  logic [ACC_WIDTH-1:0] aso_data_q, aso_data_d;

  logic                 last;
  logic                 accept;
  logic [ACC_WIDTH-1:0] sx;
  logic [ACC_WIDTH-1:0] sum;

  always_comb begin
    last      = (cnt_q == CNT_LAST);
    // The final sample may enter whenever the output register is empty or
    // being drained this same cycle.
    asi_ready = !clr && (!last || !aso_valid_q || aso_ready);
    accept    = asi_valid && asi_ready;
    sx        = ACC_WIDTH'($signed(asi_data));
    sum       = acc_q + sx;
  end

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    aso_valid_d = aso_valid_q;
    aso_data_d  = aso_data_q;

    if (aso_valid_q && aso_ready) begin
      aso_valid_d = 1'b0;
    end

    if (clr) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (accept) begin
      if (last) begin
        // A load in the same cycle as a drain overrides the clear above,
        // giving back-to-back sums with no bubble.
        aso_data_d  = sum;
        aso_valid_d = 1'b1;
        acc_d       = '0;
        cnt_d       = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      aso_valid_q <= 1'b0;
      aso_data_q  <= '0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      aso_valid_q <= aso_valid_d;
      aso_data_q  <= aso_data_d;
    end
  end

  assign aso_valid = aso_valid_q;
  assign aso_data  = aso_data_q;

endmodule

// File: tb/tb_st_sum_decimator.sv
`timescale 1ns/1ps
module tb_st_sum_decimator;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clr;
  logic        asi_valid;
  logic [31:0] asi_data;
  logic        asi_ready;
  logic        aso_valid;
  logic [39:0] aso_data;
  logic        aso_ready;

  int vectors     = 0;
  int miscompares = 0;

  st_sum_decimator #(
    .DATA_WIDTH(32),
    .DECIM     (4),
    .ACC_WIDTH (40)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (clr),
    .asi_valid(asi_valid),
    .asi_data (asi_data),
    .asi_ready(asi_ready),
    .aso_valid(aso_valid),
    .aso_data (aso_data),
    .aso_ready(aso_ready)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d);
    asi_valid = v;
    asi_data  = d;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; clr = 1'b0; aso_ready = 1'b0;
    drive(1'b0, 32'd0);
    #2;
    vectors++; if (aso_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", aso_valid); end
    vectors++; if (aso_data !== 40'd0) begin miscompares++; $display("FAIL reset_data: got %h want 0", aso_data); end
    vectors++; if (asi_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", asi_ready); end
    tick; tick;
    @(negedge clk);
    reset_n = 1'b1;
    tick;
    vectors++; if (aso_valid !== 1'b0) begin miscompares++; $display("FAIL post_reset_valid: got %b want 0", aso_valid); end
    vectors++; if (asi_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_ready: got %b want 1", asi_ready); end
  endtask

  task automatic test_basic;
    logic [31:0] s [4] = '{32'd1, 32'd2, 32'd3, 32'd4};
    aso_ready = 1'b1;
    // Junk data with valid low must not be summed.
    drive(1'b0, 32'd100);
    tick;
    vectors++; if (aso_valid !== 1'b0) begin miscompares++; $display("FAIL basic_idle_valid: got %b want 0", aso_valid); end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, s[i]);
      #1;
      vectors++; if (asi_ready !== 1'b1) begin miscompares++; $display("FAIL basic_ready[%0d]: got %b want 1", i, asi_ready); end
      tick;
      vectors++; if (aso_valid !== (i == 3)) begin miscompares++; $display("FAIL basic_valid[%0d]: got %b want %b", i, aso_valid, (i == 3)); end
    end
    vectors++; if (aso_data !== 40'd10) begin miscompares++; $display("FAIL basic_sum: got %0d want 10", aso_data); end
    drive(1'b0, 32'd0);
    tick;
    vectors++; if (aso_valid !== 1'b0) begin miscompares++; $display("FAIL basic_pulse: got %b want 0", aso_valid); end
  endtask

  task automatic test_sign;
    logic [31:0] s [8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd5, 32'd0,
                           32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    aso_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, s[i]);
      tick;
      if (i == 3) begin
        vectors++; if (aso_valid !== 1'b1 || aso_data !== 40'h00_0000_0002) begin miscompares++; $display("FAIL sign_mixed: got v=%b %h want v=1 0000000002", aso_valid, aso_data); end
      end
      if (i == 7) begin
        vectors++; if (aso_valid !== 1'b1 || aso_data !== 40'hFF_FFFF_FFFC) begin miscompares++; $display("FAIL sign_neg: got v=%b %h want v=1 fffffffffc", aso_valid, aso_data); end
      end
    end
    drive(1'b0, 32'd0);
    tick;
  endtask

  task automatic test_backpressure;
    aso_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 32'(i));
      tick;
    end
    vectors++; if (aso_valid !== 1'b1 || aso_data !== 40'd10) begin miscompares++; $display("FAIL bp_pending: got v=%b %0d want v=1 10", aso_valid, aso_data); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'd1);
      #1;
      vectors++; if (asi_ready !== 1'b1) begin miscompares++; $display("FAIL bp_accept[%0d]: got %b want 1", i, asi_ready); end
      tick;
    end
    drive(1'b1, 32'd1);
    for (int i = 0; i < 2; i++) begin
      #1;
      vectors++; if (asi_ready !== 1'b0) begin miscompares++; $display("FAIL bp_stall[%0d]: got %b want 0", i, asi_ready); end
      tick;
      vectors++; if (aso_valid !== 1'b1 || aso_data !== 40'd10) begin miscompares++; $display("FAIL bp_hold[%0d]: got v=%b %0d want v=1 10", i, aso_valid, aso_data); end
    end
    aso_ready = 1'b1;
    #1;
    vectors++; if (asi_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release_ready: got %b want 1", asi_ready); end
    tick;
    vectors++; if (aso_valid !== 1'b1 || aso_data !== 40'd4) begin miscompares++; $display("FAIL bp_no_bubble: got v=%b %0d want v=1 4", aso_valid, aso_data); end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'd1);
      tick;
      if (i == 0) begin
        vectors++; if (aso_valid !== 1'b0) begin miscompares++; $display("FAIL bp_drain: got %b want 0", aso_valid); end
      end
    end
    vectors++; if (aso_valid !== 1'b1 || aso_data !== 40'd4) begin miscompares++; $display("FAIL bp_second: got v=%b %0d want v=1 4", aso_valid, aso_data); end
    drive(1'b0, 32'd0);
    tick;
  endtask

  task automatic test_back_to_back;
    aso_ready = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      drive(1'b1, 32'd1);
      #1;
      vectors++; if (asi_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready[%0d]: got %b want 1", k, asi_ready); end
      tick;
      vectors++; if (aso_valid !== ((k % 4) == 0)) begin miscompares++; $display("FAIL b2b_valid[%0d]: got %b want %b", k, aso_valid, ((k % 4) == 0)); end
      if ((k % 4) == 0) begin
        vectors++; if (aso_data !== 40'd4) begin miscompares++; $display("FAIL b2b_sum[%0d]: got %0d want 4", k, aso_data); end
      end
    end
    drive(1'b0, 32'd0);
    tick;
  endtask

  task automatic test_clr;
    aso_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'd5);
      tick;
    end
    drive(1'b1, 32'd7); tick;
    drive(1'b1, 32'd7); tick;
    clr = 1'b1;
    drive(1'b1, 32'd99);
    #1;
    vectors++; if (asi_ready !== 1'b0) begin miscompares++; $display("FAIL clr_ready: got %b want 0", asi_ready); end
    tick;
    vectors++; if (aso_valid !== 1'b1 || aso_data !== 40'd20) begin miscompares++; $display("FAIL clr_pending: got v=%b %0d want v=1 20", aso_valid, aso_data); end
    clr = 1'b0;
    aso_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'd1);
      tick;
      if (i == 0) begin
        vectors++; if (aso_valid !== 1'b0) begin miscompares++; $display("FAIL clr_drain: got %b want 0", aso_valid); end
      end
    end
    vectors++; if (aso_valid !== 1'b1 || aso_data !== 40'd4) begin miscompares++; $display("FAIL clr_sum: got v=%b %0d want v=1 4", aso_valid, aso_data); end
    drive(1'b0, 32'd0);
    tick;
  endtask

  task automatic test_async_reset;
    aso_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'd5);
      tick;
    end
    drive(1'b1, 32'd3);
    tick;
    drive(1'b0, 32'd0);
    vectors++; if (aso_valid !== 1'b1) begin miscompares++; $display("FAIL ar_pre_valid: got %b want 1", aso_valid); end
    #3 reset_n = 1'b0;
    #1;
    vectors++; if (aso_valid !== 1'b0 || aso_data !== 40'd0) begin miscompares++; $display("FAIL ar_immediate: got v=%b %0d want v=0 0", aso_valid, aso_data); end
    vectors++; if (asi_ready !== 1'b1) begin miscompares++; $display("FAIL ar_ready: got %b want 1", asi_ready); end
    #3 reset_n = 1'b1;
    tick;
    vectors++; if (aso_valid !== 1'b0) begin miscompares++; $display("FAIL ar_after: got %b want 0", aso_valid); end
    aso_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'd2);
      tick;
    end
    vectors++; if (aso_valid !== 1'b1 || aso_data !== 40'd8) begin miscompares++; $display("FAIL ar_sum: got v=%b %0d want v=1 8", aso_valid, aso_data); end
    drive(1'b0, 32'd0);
    tick;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_sign;
    test_backpressure;
    test_back_to_back;
    test_clr;
    test_async_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
